// File: rtl/edge_update_queue_pkg.sv
// Shared widths, register map and payload type for the edge-weight update queue.
package edge_update_queue_pkg;

  localparam int unsigned PRED_WIDTH   = 7;
  localparam int unsigned WEIGHT_WIDTH = 31;

  localparam int unsigned PRED_W_DEF   = PRED_WIDTH + 1;
  localparam int unsigned WEIGHT_W_DEF = WEIGHT_WIDTH + 1;
  localparam int unsigned DEPTH_DEF    = 16;
  localparam int unsigned CNT_W_DEF    = $clog2(DEPTH_DEF) + 1;

  // Write-side register map
  localparam logic [2:0] ADDR_PAIR   = 3'd0;
  localparam logic [2:0] ADDR_WEIGHT = 3'd1;
  localparam logic [2:0] ADDR_CLR    = 3'd2;
  localparam logic [2:0] ADDR_FLUSH  = 3'd3;

  // Read-side register map
  localparam logic [2:0] ADDR_OCC    = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;

  // Status word bit positions
  localparam int unsigned ST_EMPTY  = 0;
  localparam int unsigned ST_FULL   = 1;
  localparam int unsigned ST_OVF    = 2;
  localparam int unsigned ST_ORPHAN = 3;

  typedef struct packed {
    logic [PRED_W_DEF-1:0]   src;
    logic [PRED_W_DEF-1:0]   dst;
    logic [WEIGHT_W_DEF-1:0] weight;
  } edge_update_t;

endpackage

// File: rtl/edge_update_queue_if.sv
// Avalon-MM slave port plus the valid/ready update stream toward the container.
interface edge_update_queue_if
  import edge_update_queue_pkg::*;
#(
  parameter int unsigned PRED_W   = PRED_W_DEF,
  parameter int unsigned WEIGHT_W = WEIGHT_W_DEF
) ();

  logic                chipselect;
  logic                write;
  logic                read;
  logic [2:0]          address;
  logic [WEIGHT_W-1:0] writedata;
  logic [31:0]         readdata;

  logic                upd_valid;
  logic [PRED_W-1:0]   upd_src;
  logic [PRED_W-1:0]   upd_dst;
  logic [WEIGHT_W-1:0] upd_weight;
  logic                upd_ready;

  modport slave (
    input  chipselect, write, read, address, writedata, upd_ready,
    output readdata, upd_valid, upd_src, upd_dst, upd_weight
  );

  modport master (
    output chipselect, write, read, address, writedata, upd_ready,
    input  readdata, upd_valid, upd_src, upd_dst, upd_weight
  );

endinterface

// File: rtl/edge_update_queue_sync_fifo.sv
// Power-of-two ring buffer with push/pop/flush and an occupancy count.
module edge_update_queue_sync_fifo
  import edge_update_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1,
  parameter type         T     = edge_update_t
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  T                 i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output T                 o_head_c,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full_c,
  output logic             o_empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  T                 r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full_c  = (r_count == CNT_W'(DEPTH));
  assign o_empty_c = (r_count == '0);

  // Flush overrides any same-cycle push or pop
  assign w_push = i_push && !o_full_c && !i_flush;
  assign w_pop  = i_pop && !o_empty_c && !i_flush;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_c = r_mem[r_rd_ptr];
  assign o_count  = r_count;

endmodule

// File: rtl/edge_update_queue.sv
// Avalon slave that pairs (src,dst) and weight writes, queues completed updates
// and presents them one at a time through a first-word-fall-through register.
module edge_update_queue
  import edge_update_queue_pkg::*;
#(
  parameter int unsigned PRED_W   = PRED_W_DEF,
  parameter int unsigned WEIGHT_W = WEIGHT_W_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  edge_update_queue_if.slave  bus
);

  logic                w_wr;
  logic                w_rd;
  logic                w_pair_wr;
  logic                w_wt_wr;
  logic                w_clr;
  logic                w_flush;

  logic [CNT_W-1:0]    w_fifo_count;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [CNT_W-1:0]    w_occ;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_load;
  logic [3:0]          w_status;
  edge_update_t        w_push_data;
  edge_update_t        w_head;

  logic                r_staged;
  logic [PRED_W-1:0]   r_staged_src;
  logic [PRED_W-1:0]   r_staged_dst;
  logic                r_overflow;
  logic                r_orphan;
  logic                r_upd_valid;
  edge_update_t        r_upd;
  logic [31:0]         r_readdata;

  assign w_wr      = bus.chipselect && bus.write;
  assign w_rd      = bus.chipselect && bus.read;
  assign w_pair_wr = w_wr && (bus.address == ADDR_PAIR);
  assign w_wt_wr   = w_wr && (bus.address == ADDR_WEIGHT);
  assign w_clr     = w_wr && (bus.address == ADDR_CLR);
  assign w_flush   = w_wr && (bus.address == ADDR_FLUSH);

  // Occupancy covers both storage and the output register
  assign w_occ   = w_fifo_count + CNT_W'(r_upd_valid);
  assign w_full  = (w_occ == CNT_W'(DEPTH));
  assign w_empty = (w_occ == '0);

  assign w_push = w_wt_wr && r_staged && !w_full && !w_fifo_full;
  assign w_load = !w_flush && !w_fifo_empty && (!r_upd_valid || bus.upd_ready);

  assign w_push_data = '{src: r_staged_src, dst: r_staged_dst, weight: bus.writedata};

  always_comb begin
    w_status = {r_orphan, r_overflow, w_full, w_empty};
  end

  edge_update_queue_sync_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .T     (edge_update_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .i_push    (w_push),
    .i_data    (w_push_data),
    .i_pop     (w_load),
    .i_flush   (w_flush),
    .o_head_c  (w_head),
    .o_count   (w_fifo_count),
    .o_full_c  (w_fifo_full),
    .o_empty_c (w_fifo_empty)
  );

  // Pair staging; a weight write always consumes the staged pair, pushed or dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_staged     <= 1'b0;
      r_staged_src <= '0;
      r_staged_dst <= '0;
    end else if (w_pair_wr) begin
      r_staged     <= 1'b1;
      r_staged_src <= bus.writedata[2*PRED_W-1:PRED_W];
      r_staged_dst <= bus.writedata[PRED_W-1:0];
    end else if (w_wt_wr) begin
      r_staged     <= 1'b0;
    end
  end

  // Sticky error flags, cleared only by an explicit clear write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
      r_orphan   <= 1'b0;
    end else if (w_clr) begin
      r_overflow <= 1'b0;
      r_orphan   <= 1'b0;
    end else if (w_wt_wr) begin
      if (!r_staged) begin
        r_orphan <= 1'b1;
      end else if (w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // FWFT output register reloads from storage on the same edge as a transfer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_upd_valid <= 1'b0;
      r_upd       <= '0;
    end else if (w_flush) begin
      r_upd_valid <= 1'b0;
    end else if (w_load) begin
      r_upd_valid <= 1'b1;
      r_upd       <= w_head;
    end else if (bus.upd_ready) begin
      r_upd_valid <= 1'b0;
    end
  end

  // Reads sample pre-write state and appear one cycle later
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_readdata <= '0;
    end else if (w_rd) begin
      case (bus.address)
        ADDR_OCC:    r_readdata <= 32'(w_occ);
        ADDR_STATUS: r_readdata <= {28'b0, w_status};
        default:     r_readdata <= '0;
      endcase
    end else begin
      r_readdata <= '0;
    end
  end

  assign bus.readdata   = r_readdata;
  assign bus.upd_valid  = r_upd_valid;
  assign bus.upd_src    = r_upd.src;
  assign bus.upd_dst    = r_upd.dst;
  assign bus.upd_weight = r_upd.weight;

endmodule

// File: tb/tb_edge_update_queue.sv
// Directed table, corner-case sequences and randomized traffic against a queue model.
module tb_edge_update_queue;
  import edge_update_queue_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   edge_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  edge_update_queue_if bus ();

  edge_update_queue dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0]  src;
    logic [7:0]  dst;
    logic [31:0] w;
    int          pe;
  } m_t;

  m_t         mq[$];
  bit         m_staged, m_ovf, m_orph;
  logic [7:0] m_src, m_dst;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [2:0]  a;
    logic [31:0] d;
    logic        rdy;
    logic        ev;
    logic [7:0]  es;
    logic [7:0]  ed;
    logic [31:0] ew;
    logic        crd;
    logic [31:0] erd;
  } vec_t;

  vec_t tv[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [2:0] a,
                       input logic [31:0] d, input logic rdy);
    bus.chipselect = wr || rd;
    bus.write      = wr;
    bus.read       = rd;
    bus.address    = a;
    bus.writedata  = d;
    bus.upd_ready  = rdy;
  endtask

  task automatic model_clear();
    mq.delete();
    m_staged = 0;
    m_ovf    = 0;
    m_orph   = 0;
    m_src    = '0;
    m_dst    = '0;
  endtask

  task automatic do_reset();
    drive(0, 0, 3'd0, 32'd0, 1'b0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
  endtask

  // One clock of stimulus checked against the queue model
  task automatic mcycle(input logic wr, input logic rd, input logic [2:0] a,
                        input logic [31:0] d, input logic rdy, output bit xfer);
    int          pre;
    bit          exp_v;
    logic [31:0] exp_rd;
    m_t          e;
    drive(wr, rd, a, d, rdy);
    pre   = mq.size();
    exp_v = 0;
    if (pre > 0) exp_v = (edge_cnt >= mq[0].pe + 1);
    chk("upd_valid", 32'(bus.upd_valid), 32'(exp_v));
    if (exp_v) begin
      chk("upd_src", 32'(bus.upd_src), 32'(mq[0].src));
      chk("upd_dst", 32'(bus.upd_dst), 32'(mq[0].dst));
      chk("upd_weight", bus.upd_weight, mq[0].w);
    end
    exp_rd = '0;
    if (a == 3'd0) exp_rd = 32'(pre);
    if (a == 3'd1) begin
      exp_rd[ST_EMPTY]  = (pre == 0);
      exp_rd[ST_FULL]   = (pre == int'(DEPTH_DEF));
      exp_rd[ST_OVF]    = m_ovf;
      exp_rd[ST_ORPHAN] = m_orph;
    end
    xfer = exp_v && rdy && !(wr && a == 3'd3);
    if (xfer) void'(mq.pop_front());
    if (wr) begin
      case (a)
        3'd0: begin m_staged = 1; m_src = d[15:8]; m_dst = d[7:0]; end
        3'd1: begin
          if (m_staged) begin
            if (pre == int'(DEPTH_DEF)) m_ovf = 1;
            else begin
              e.src = m_src; e.dst = m_dst; e.w = d; e.pe = edge_cnt + 1;
              mq.push_back(e);
            end
            m_staged = 0;
          end else m_orph = 1;
        end
        3'd2: begin m_ovf = 0; m_orph = 0; end
        3'd3: mq.delete();
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    if (rd) chk("readdata", bus.readdata, exp_rd);
  endtask

  task automatic push_upd(input logic [7:0] s, input logic [7:0] t, input logic [31:0] w,
                          input logic rdy);
    bit x;
    mcycle(1, 0, 3'd0, {16'h0, s, t}, rdy, x);
    mcycle(1, 0, 3'd1, w, rdy, x);
  endtask

  initial begin
    bit x;
    int n;
    logic [2:0] ra;
    int r, rp;

    tv[0]  = '{1, 0, 3'd0, 32'h0000_0305, 0, 0, 8'd0, 8'd0, 32'h0, 0, 32'h0};
    tv[1]  = '{1, 0, 3'd1, 32'hFFFF_FFF9, 0, 0, 8'd0, 8'd0, 32'h0, 0, 32'h0};
    tv[2]  = '{0, 0, 3'd0, 32'h0,         0, 1, 8'd3, 8'd5, 32'hFFFF_FFF9, 0, 32'h0};
    tv[3]  = '{0, 1, 3'd0, 32'h0,         0, 1, 8'd3, 8'd5, 32'hFFFF_FFF9, 1, 32'd1};
    tv[4]  = '{0, 1, 3'd1, 32'h0,         0, 1, 8'd3, 8'd5, 32'hFFFF_FFF9, 1, 32'd0};
    tv[5]  = '{1, 0, 3'd1, 32'h5,         0, 1, 8'd3, 8'd5, 32'hFFFF_FFF9, 0, 32'h0};
    tv[6]  = '{0, 1, 3'd1, 32'h0,         0, 1, 8'd3, 8'd5, 32'hFFFF_FFF9, 1, 32'd8};
    tv[7]  = '{0, 1, 3'd0, 32'h0,         0, 1, 8'd3, 8'd5, 32'hFFFF_FFF9, 1, 32'd1};
    tv[8]  = '{1, 0, 3'd2, 32'h0,         0, 1, 8'd3, 8'd5, 32'hFFFF_FFF9, 0, 32'h0};
    tv[9]  = '{0, 0, 3'd0, 32'h0,         1, 0, 8'd0, 8'd0, 32'h0, 0, 32'h0};
    tv[10] = '{0, 1, 3'd1, 32'h0,         0, 0, 8'd0, 8'd0, 32'h0, 1, 32'd1};

    do_reset();
    chk("reset_valid", 32'(bus.upd_valid), 32'd0);
    chk("reset_readdata", bus.readdata, 32'd0);
    chk("reset_weight", bus.upd_weight, 32'd0);

    // Directed table: first update, orphan, clear
    for (int i = 0; i < 11; i++) begin
      drive(tv[i].wr, tv[i].rd, tv[i].a, tv[i].d, tv[i].rdy);
      @(posedge clk);
      #1;
      chk($sformatf("tv%0d_valid", i), 32'(bus.upd_valid), 32'(tv[i].ev));
      if (tv[i].ev) begin
        chk($sformatf("tv%0d_src", i), 32'(bus.upd_src), 32'(tv[i].es));
        chk($sformatf("tv%0d_dst", i), 32'(bus.upd_dst), 32'(tv[i].ed));
        chk($sformatf("tv%0d_weight", i), bus.upd_weight, tv[i].ew);
      end
      if (tv[i].crd) chk($sformatf("tv%0d_readdata", i), bus.readdata, tv[i].erd);
    end

    // Fill to capacity, overflow the 17th, drain in order
    do_reset();
    for (int i = 1; i <= 17; i++) push_upd(8'(i), 8'(i + 100), 32'(i * 1000 - 9000), 1'b0);
    mcycle(0, 1, 3'd0, 32'h0, 0, x);
    chk("full_occ", bus.readdata, 32'd16);
    mcycle(0, 1, 3'd1, 32'h0, 0, x);
    chk("full_status", bus.readdata, 32'b0110);
    n = 0;
    for (int i = 0; i < 16; i++) begin
      mcycle(0, 0, 3'd0, 32'h0, 1, x);
      n += int'(x);
    end
    chk("drain_count", 32'(n), 32'd16);
    mcycle(0, 1, 3'd0, 32'h0, 1, x);
    chk("drained_occ", bus.readdata, 32'd0);

    // Ready toggling 1,0,1,1 over four queued updates
    do_reset();
    for (int i = 0; i < 4; i++) push_upd(8'(40 + i), 8'(50 + i), 32'(-i - 1), 1'b0);
    mcycle(0, 0, 3'd0, 32'h0, 0, x);
    n = 0;
    mcycle(0, 0, 3'd0, 32'h0, 1, x); n += int'(x);
    mcycle(0, 0, 3'd0, 32'h0, 0, x); n += int'(x);
    mcycle(0, 0, 3'd0, 32'h0, 1, x); n += int'(x);
    mcycle(0, 0, 3'd0, 32'h0, 1, x); n += int'(x);
    chk("toggle_xfers", 32'(n), 32'd3);
    chk("toggle_last_src", 32'(bus.upd_src), 32'd43);

    // Flush with five queued, then normal delivery
    for (int i = 0; i < 4; i++) push_upd(8'(60 + i), 8'(70 + i), 32'(i * 7), 1'b0);
    mcycle(0, 1, 3'd0, 32'h0, 0, x);
    chk("preflush_occ", bus.readdata, 32'd5);
    mcycle(1, 0, 3'd3, 32'h0, 1, x);
    chk("flush_valid", 32'(bus.upd_valid), 32'd0);
    mcycle(0, 1, 3'd0, 32'h0, 0, x);
    chk("flush_occ", bus.readdata, 32'd0);
    push_upd(8'd9, 8'd11, 32'h8000_0001, 1'b0);
    mcycle(0, 0, 3'd0, 32'h0, 0, x);
    chk("postflush_valid", 32'(bus.upd_valid), 32'd1);
    chk("postflush_weight", bus.upd_weight, 32'h8000_0001);

    // Asynchronous reset mid-drain
    for (int i = 0; i < 5; i++) push_upd(8'(i), 8'(i), 32'(i), 1'b0);
    mcycle(0, 0, 3'd0, 32'h0, 1, x);
    mcycle(0, 1, 3'd0, 32'h0, 1, x);
    #2;
    reset = 1'b0;
    #1;
    chk("async_valid", 32'(bus.upd_valid), 32'd0);
    chk("async_readdata", bus.readdata, 32'd0);
    model_clear();
    drive(0, 0, 3'd0, 32'h0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    mcycle(0, 1, 3'd0, 32'h0, 1, x);
    chk("async_occ", bus.readdata, 32'd0);
    mcycle(0, 1, 3'd1, 32'h0, 1, x);
    chk("async_status", bus.readdata, 32'd1);

    // Randomized traffic with phases of mostly-stalled, mostly-open and mixed ready
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic rdy;
      rp  = ((c / 150) % 3 == 0) ? 10 : (((c / 150) % 3 == 1) ? 90 : 50);
      rdy = ($urandom_range(0, 99) < rp);
      r   = $urandom_range(0, 99);
      if (r < 35)       mcycle(1, 0, 3'd0, $urandom, rdy, x);
      else if (r < 70)  mcycle(1, 0, 3'd1, $urandom, rdy, x);
      else if (r < 80) begin
        ra = 3'($urandom_range(0, 7));
        mcycle(0, 1, (ra > 3'd2) ? ra : 3'($urandom_range(0, 1)), 32'h0, rdy, x);
      end
      else if (r < 82)  mcycle(1, 0, 3'd2, 32'h0, rdy, x);
      else if (r < 83)  mcycle(1, 0, 3'd3, 32'h0, rdy, x);
      else if (r < 86)  mcycle(1, 1, 3'($urandom_range(1, 2)), $urandom, rdy, x);
      else if (r < 88)  mcycle(1, 0, 3'($urandom_range(4, 7)), $urandom, rdy, x);
      else              mcycle(0, 0, 3'd0, 32'h0, rdy, x);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/edge_update_queue.md
Name: edge_update_queue

Overview:
- Upstream stage of the arbitrage engine: the Avalon-MM slave that accepts edge-weight updates from the HPS.
- Pairs a (src,dst) write with its weight write and buffers the completed updates in a FIFO.
- Presents one update at a time to the Bellman-Ford container over a valid/ready handshake.
- Decouples software write bursts from container relaxation passes and reports occupancy and error status.

Parameters:
- PRED_W, default `PRED_WIDTH+1: vertex index width.
- WEIGHT_W, default `WEIGHT_WIDTH+1: edge weight width; also the writedata width.
- DEPTH, default 16: total update capacity, including the output register; power of two.
- CNT_W, default $clog2(DEPTH)+1: occupancy counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- chipselect  in  1  Avalon slave select
- write  in  1  Avalon write strobe
- read  in  1  Avalon read strobe
- address  in  3  register address
- writedata  in  WEIGHT_W  write data
- readdata  out  32  read data, valid the cycle after read
- upd_valid  out  1  output entry valid
- upd_src  out  PRED_W  update source vertex
- upd_dst  out  PRED_W  update destination vertex
- upd_weight  out  WEIGHT_W  update weight, two's complement
- upd_ready  in  1  container accepts the entry

Behaviour:
- Reset (reset low, asynchronous): all of the following clear to 0: occupancy, pointers, staged flag, staged src/dst, overflow, orphan, upd_valid, upd_src, upd_dst, upd_weight, readdata. Reset asserted mid-transfer discards all entries.
- Register writes (chipselect && write):
  - addr 0: staged_src <= writedata[2*PRED_W-1:PRED_W], staged_dst <= writedata[PRED_W-1:0], staged <= 1. Rewriting before the weight write overwrites the staged pair.
  - addr 1, staged && occ<DEPTH: push {staged_src, staged_dst, writedata}; staged <= 0.
  - addr 1, staged && occ==DEPTH: drop the update, overflow <= 1, staged <= 0. Fullness uses the pre-cycle occupancy; a simultaneous pop does not rescue the push.
  - addr 1, !staged: drop the update, orphan <= 1.
  - addr 2: clear overflow and orphan.
  - addr 3: flush. Occupancy <= 0, upd_valid <= 0 next cycle. Staged flag and status bits are unchanged. A flush wins over a same-cycle pop.
  - addr 4-7: ignored.
- Register reads (chipselect && read), registered, 1-cycle latency:
  - addr 0: zero-extended occupancy.
  - addr 1: {28'b0, orphan, overflow, full, empty}.
  - Other addresses: 0.
  - Write and read in the same cycle: the read returns the pre-write value.
- Output stage:
  - First-word-fall-through register holding the FIFO head.
  - Transfer occurs when upd_valid && upd_ready; the register reloads from storage in the same cycle (back-to-back transfers at 1 per cycle).
  - Latency from an empty queue: weight write at edge N gives upd_valid=1 after edge N+1.
  - While upd_valid && !upd_ready, upd_src, upd_dst and upd_weight are held stable.
- Occupancy counts storage entries plus the output register. Full when occ==DEPTH, empty when occ==0. Push and pop in the same cycle leave occupancy unchanged.
- Pointers wrap modulo DEPTH. FIFO order is preserved exactly.
- Weight is passed through bit-exact; no sign extension or saturation.

Decomposition:
- hft_pkg: edge_update_t struct {src, dst, weight}; register address constants ADDR_PAIR=0, ADDR_WEIGHT=1, ADDR_CLR=2, ADDR_FLUSH=3; status bit indices (EMPTY=0, FULL=1, OVF=2, ORPHAN=3); derived from Const.vh widths.
- One sub-module: sync_fifo, a parameterised ring buffer (push/pop/flush, count, full/empty) storing edge_update_t.
- edge_update_queue contains the Avalon decode, staging logic, status bits and FWFT output register.

Test Plan:
- Reset, then write addr0=(src 3, dst 5) and addr1=-7; hold upd_ready=0 -> upd_valid=1 after 2 edges with src=3, dst=5, weight=-7 held stable; read addr0 returns 1.
- 16 paired writes with upd_ready=0, then a 17th pair -> occ=16, status=0b0110 (full, overflow); 17th update absent; drain with ready=1 gives updates 1..16 in order at 1 per cycle.
- Weight write with no staged pair -> nothing pushed, status bit3=1; write addr2 -> status returns to 0b0001.
- 4 queued updates, upd_ready toggling 1,0,1,1 -> exactly 3 transfers, no duplicates or skips; head held during ready=0.
- Flush with 5 queued and upd_valid=1 -> upd_valid=0 next cycle, occ=0; a subsequent pair+weight is delivered normally.
- Assert reset mid-drain, asynchronously between edges -> upd_valid and readdata 0 immediately; after release, occ=0 and the queue is empty.
